// File: rtl/bitlet_weight_scheduler.sv
// bitlet_weight_scheduler: splits one group of signed weights into bit-planes
// and, each beat, hands the Bitlet MAC the next set lane index for every bit
// significance. Also sequences the MAC accumulator (load / drain / done).
//
// Handshake: a weight group transfers on a rising edge where w_valid && w_ready.
// w_valid may be asserted at any time; w_ready is high in IDLE and on the cycle
// the last beat of the current group issues (back-to-back). It is never high
// in DRAIN or while reset is asserted.
module bitlet_weight_scheduler #(
  parameter int DATA_WIDTH    = 8,
  parameter int VEC_LENGTH    = 32,
  parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]    w_in,
  input  logic                                     w_valid,
  output logic                                     w_ready,
  input  logic                                     stall,
  output logic [DATA_WIDTH-1:0][MUX_SEL_WIDTH-1:0] act_sel,
  output logic [DATA_WIDTH-1:0]                    act_val,
  output logic                                     mac_en,
  output logic                                     load_accum,
  output logic                                     acc_done,
  output logic                                     busy,
  output logic [1:0]                               dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                                  state_q, state_d;
  logic [DATA_WIDTH-1:0][VEC_LENGTH-1:0]   plane_q, plane_d;
  logic                                    first_q, first_d;
  logic                                    load_pend_q, load_pend_d;
  logic                                    done_pend_q, done_pend_d;
  logic                                    acc_done_q, acc_done_d;

  logic [DATA_WIDTH-1:0][VEC_LENGTH-1:0]    plane_in;
  logic [DATA_WIDTH-1:0][VEC_LENGTH-1:0]    plane_clr;
  logic [DATA_WIDTH-1:0][MUX_SEL_WIDTH-1:0] sel_raw;
  logic                                     in_run;
  logic                                     beat;
  logic                                     last_beat;
  logic                                     accept;

  // Transpose the incoming group into bit-planes and precompute each plane
  // with its lowest set bit removed (the plane after this beat).
  always_comb begin
    plane_in  = '0;
    plane_clr = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      for (int i = 0; i < VEC_LENGTH; i++) begin
        plane_in[j][i] = w_in[i][j];
      end
      plane_clr[j] = plane_q[j] & (plane_q[j] - VEC_LENGTH'(1));
    end
  end

  // Lowest set lane per plane; an empty plane reports lane 0.
  always_comb begin
    sel_raw = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      for (int i = VEC_LENGTH - 1; i >= 0; i--) begin
        if (plane_q[j][i]) begin
          sel_raw[j] = MUX_SEL_WIDTH'(i);
        end
      end
    end
  end

  // Beat / handshake / MAC control decode; everything is forced quiet in reset.
  always_comb begin
    in_run     = (state_q == ST_RUN);
    beat       = reset && in_run && !stall;
    last_beat  = beat && (plane_clr == '0);
    w_ready    = reset && ((state_q == ST_IDLE) || last_beat);
    accept     = w_valid && w_ready;
    mac_en     = reset && !stall && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    load_accum = mac_en && load_pend_q;
    act_sel    = '0;
    act_val    = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      act_val[j] = reset && in_run && (|plane_q[j]);
      act_sel[j] = reset ? sel_raw[j] : '0;
    end
    busy      = (state_q != ST_IDLE);
    acc_done  = acc_done_q;
    dbg_state = state_q;
  end

  // Next-state logic: plane consumption, FSM moves and accumulator bookkeeping.
  always_comb begin
    state_d = state_q;
    plane_d = plane_q;
    first_d = first_q;
    if (beat) begin
      plane_d = plane_clr;
      first_d = 1'b0;
    end
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_RUN;
      ST_RUN:   if (last_beat) state_d = accept ? ST_RUN : ST_DRAIN;
      ST_DRAIN: if (!stall) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (accept) begin
      plane_d = plane_in;
      first_d = 1'b1;
    end
    // The MAC loads its accumulator on the enabled cycle after a first beat,
    // and finishes a group on the enabled cycle after its last beat.
    load_pend_d = (beat && first_q) ? 1'b1 : (mac_en ? 1'b0 : load_pend_q);
    done_pend_d = last_beat ? 1'b1 : (mac_en ? 1'b0 : done_pend_q);
    acc_done_d  = mac_en && done_pend_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      plane_q     <= '0;
      first_q     <= 1'b0;
      load_pend_q <= 1'b0;
      done_pend_q <= 1'b0;
      acc_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      plane_q     <= plane_d;
      first_q     <= first_d;
      load_pend_q <= load_pend_d;
      done_pend_q <= done_pend_d;
      acc_done_q  <= acc_done_d;
    end
  end

endmodule

// File: tb/tb_bitlet_weight_scheduler.sv
// Directed bench for bitlet_weight_scheduler with a behavioural MAC model and
// expected-beat / expected-result queues.
module tb_bitlet_weight_scheduler;

  localparam int DW = 8;
  localparam int VL = 32;
  localparam int SW = 5;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;

  typedef struct packed {
    logic [DW-1:0][SW-1:0] sel;
    logic [DW-1:0]         val;
    logic                  first;
    logic                  last;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [VL-1:0][DW-1:0]  w_in;
  logic                   w_valid;
  logic                   w_ready;
  logic                   stall;
  logic [DW-1:0][SW-1:0]  act_sel;
  logic [DW-1:0]          act_val;
  logic                   mac_en;
  logic                   load_accum;
  logic                   acc_done;
  logic                   busy;
  logic [1:0]             dbg_state;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    act_i[VL];
  beat_t beat_q[$];
  int    res_q[$];
  int    done_cyc_q[$];
  bit    prev_first = 1'b0;
  bit    done_pend = 1'b0;
  bit    exp_done = 1'b0;
  int    psum_reg = 0;
  int    accum = 0;

  bitlet_weight_scheduler #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) dut (
    .clk        (clk),
    .reset      (reset),
    .w_in       (w_in),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .stall      (stall),
    .act_sel    (act_sel),
    .act_val    (act_val),
    .mac_en     (mac_en),
    .load_accum (load_accum),
    .acc_done   (acc_done),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW*SW-1:0] mask_sel(input logic [DW-1:0][SW-1:0] s,
                                                input logic [DW-1:0] v);
    logic [DW-1:0][SW-1:0] m;
    m = '0;
    for (int j = 0; j < DW; j++) if (v[j]) m[j] = s[j];
    return m;
  endfunction

  // Partial sum the MAC forms from one beat; the top plane carries negative weight.
  function automatic int psum_of(input logic [DW-1:0][SW-1:0] s, input logic [DW-1:0] v);
    int p;
    p = 0;
    for (int j = 0; j < DW; j++) begin
      if (v[j]) begin
        if (j == DW - 1) p = p - act_i[s[j]] * (1 << j);
        else             p = p + act_i[s[j]] * (1 << j);
      end
    end
    return p;
  endfunction

  // Expected beats: plane j's k-th beat picks its k-th set lane in ascending order.
  task automatic push_expect(input logic [VL-1:0][DW-1:0] w);
    int    cnt[DW];
    int    idx[DW][VL];
    int    n;
    int    sum;
    beat_t rec;
    n = 1;
    for (int j = 0; j < DW; j++) begin
      cnt[j] = 0;
      for (int i = 0; i < VL; i++) begin
        if (w[i][j]) begin
          idx[j][cnt[j]] = i;
          cnt[j]++;
        end
      end
      if (cnt[j] > n) n = cnt[j];
    end
    for (int k = 0; k < n; k++) begin
      rec = '0;
      for (int j = 0; j < DW; j++) begin
        if (k < cnt[j]) begin
          rec.sel[j] = SW'(idx[j][k]);
          rec.val[j] = 1'b1;
        end
      end
      rec.first = (k == 0);
      rec.last  = (k == n - 1);
      beat_q.push_back(rec);
    end
    sum = 0;
    for (int i = 0; i < VL; i++) sum = sum + act_i[i] * int'($signed(w[i]));
    res_q.push_back(sum);
  endtask

  function automatic int done_at(input int k);
    if (k < 0 || k >= done_cyc_q.size()) return -1;
    return done_cyc_q[k];
  endfunction

  // Monitor + MAC model, sampled on the falling edge
  always @(negedge clk) begin
    beat_t rec;
    bit    is_beat;
    bit    nxt_done;
    if (!reset) begin
      chk("rst_w_ready", w_ready, 0);
      chk("rst_mac_en", mac_en, 0);
      chk("rst_act_val", act_val, 0);
      chk("rst_act_sel", act_sel, 0);
      beat_q.delete();
      res_q.delete();
      prev_first = 1'b0;
      done_pend  = 1'b0;
      exp_done   = 1'b0;
      psum_reg   = 0;
      accum      = 0;
    end else begin
      chk("acc_done", acc_done, exp_done);
      if (acc_done) begin
        checks++;
        assert (res_q.size() > 0) else begin
          errors++;
          $error("FAIL result_unexpected: observed acc_done, expected no pending group");
        end
        if (res_q.size() > 0) chk("result", accum, res_q.pop_front());
        done_cyc_q.push_back(cyc);
      end
      chk("mac_en", mac_en, (!stall && dbg_state != S_IDLE));
      if (dbg_state != S_RUN) chk("act_val_not_run", act_val, 0);
      nxt_done = 1'b0;
      if (mac_en) begin
        chk("load_accum", load_accum, prev_first);
        is_beat = (dbg_state == S_RUN);
        rec = '0;
        if (is_beat) begin
          checks++;
          assert (beat_q.size() > 0) else begin
            errors++;
            $error("FAIL beat_unexpected: observed extra beat, expected none");
          end
          if (beat_q.size() > 0) begin
            rec = beat_q.pop_front();
            chk("act_val", act_val, rec.val);
            chk("act_sel", mask_sel(act_sel, rec.val), rec.sel);
          end
        end
        nxt_done   = done_pend;
        done_pend  = is_beat && rec.last;
        prev_first = is_beat && rec.first;
        accum      = load_accum ? psum_reg : accum + psum_reg;
        psum_reg   = psum_of(act_sel, act_val);
      end else begin
        chk("load_accum_off", load_accum, 0);
        if (dbg_state == S_RUN && beat_q.size() > 0) begin
          chk("hold_act_val", act_val, beat_q[0].val);
          chk("hold_act_sel", mask_sel(act_sel, beat_q[0].val), beat_q[0].sel);
        end
      end
      exp_done = nxt_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: offer a group and return the cycle index in which it was accepted.
  task automatic send_group(input logic [VL-1:0][DW-1:0] w, output int acc_cyc);
    w_in    = w;
    w_valid = 1'b1;
    acc_cyc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (w_ready) begin
        acc_cyc = cyc;
        push_expect(w);
        tick();
        break;
      end
      tick();
    end
    w_valid = 1'b0;
    checks++;
    assert (acc_cyc >= 0) else begin
      errors++;
      $error("FAIL accept: observed no w_ready, expected accept within 200 cycles");
    end
  endtask

  task automatic wait_done(input int limit);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      #1;
      if (res_q.size() == 0 && beat_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL wait_done: observed %0d pending results, expected 0 within %0d cycles",
             res_q.size(), limit);
    end
    tick();
  endtask

  initial begin
    logic [VL-1:0][DW-1:0] w;
    logic [VL-1:0][DW-1:0] w2;
    int a;
    int a2;

    reset   = 1'b0;
    w_valid = 1'b0;
    stall   = 1'b0;
    w_in    = '0;
    for (int i = 0; i < VL; i++) act_i[i] = int'($urandom_range(0, 255)) - 128;

    // Reset state
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_acc_done", acc_done, 0);
    chk("reset_load_accum", load_accum, 0);
    reset = 1'b1;
    #1;
    chk("idle_w_ready", w_ready, 1);

    // Mixed group: 3 beats, done at accept+5
    w = '0;
    w[0] = 8'h01; w[5] = 8'h81; w[31] = 8'h03;
    done_cyc_q.delete();
    send_group(w, a);
    wait_done(50);
    chk("mixed_done_count", done_cyc_q.size(), 1);
    chk("mixed_done_cycle", done_at(0), a + 5);

    // All-zero group: one empty beat, drain, done at accept+3
    w = '0;
    done_cyc_q.delete();
    send_group(w, a);
    wait_done(50);
    chk("zero_done_count", done_cyc_q.size(), 1);
    chk("zero_done_cycle", done_at(0), a + 3);

    // All ones: 32 beats
    for (int i = 0; i < VL; i++) w[i] = 8'hFF;
    done_cyc_q.delete();
    send_group(w, a);
    wait_done(100);
    chk("ff_done_cycle", done_at(0), a + 34);

    // Back-to-back two 2-beat groups
    w = '0;  w[1] = 8'h05; w[9] = 8'h01;
    w2 = '0; w2[3] = 8'h82; w2[20] = 8'h86;
    done_cyc_q.delete();
    send_group(w, a);
    send_group(w2, a2);
    wait_done(50);
    chk("b2b_accept_gap", a2 - a, 2);
    chk("b2b_done_count", done_cyc_q.size(), 2);
    chk("b2b_done_gap", done_at(1) - done_at(0), 2);
    chk("b2b_first_done", done_at(0), a + 4);

    // Stall for 3 cycles during beat 2 of a 3-beat group
    w = '0; w[2] = 8'h07; w[7] = 8'h03; w[30] = 8'h41;
    done_cyc_q.delete();
    send_group(w, a);
    tick();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    wait_done(50);
    chk("stall_done_cycle", done_at(0), a + 8);

    // Random sparse groups, back-to-back
    done_cyc_q.delete();
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < VL; i++)
        w[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      send_group(w, a);
    end
    wait_done(200);
    chk("rand_done_count", done_cyc_q.size(), 4);

    // Reset mid-group
    for (int i = 0; i < VL; i++) w[i] = 8'hFF;
    done_cyc_q.delete();
    send_group(w, a);
    repeat (5) tick();
    reset = 1'b0;
    tick();
    chk("midrst_mac_en", mac_en, 0);
    chk("midrst_act_val", act_val, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_acc_done", acc_done, 0);
    reset = 1'b1;
    #1;
    chk("midrst_w_ready", w_ready, 1);
    chk("midrst_no_done", done_cyc_q.size(), 0);
    w = '0;
    w[0] = 8'h01; w[5] = 8'h81; w[31] = 8'h03;
    send_group(w, a);
    wait_done(50);
    chk("post_rst_done_cycle", done_at(0), a + 5);

    repeat (3) tick();
    chk("end_beats_empty", beat_q.size(), 0);
    chk("end_results_empty", res_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
